// File: rtl/dffram_pkg.sv
// Shared definitions for the DFFRAM Wishbone bridge: cycle-type codes, FSM states, default depth.
package dffram_pkg;

  localparam int MEM_WORDS_DEF = 256;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_ACK  = 2'd2,
    ERR_ACK = 2'd3
  } state_e;

endpackage

// File: rtl/dffram_wb_bridge.sv
// Wishbone B4 classic slave in front of one DFFRAM macro; supports incrementing read
// bursts at one word per clock and flags out-of-range word indices with err.
module dffram_wb_bridge
  import dffram_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [AW+1:0]   wbs_adr_i,
  input  logic [DW/8-1:0] wbs_sel_i,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic [2:0]      wbs_cti_i,
  output logic [DW-1:0]   wbs_dat_o,
  output logic            wbs_ack_o,
  output logic            wbs_err_o,
  output logic            ram_en_o,
  output logic [DW/8-1:0] ram_we_o,
  output logic [AW-1:0]   ram_a_o,
  output logic [DW-1:0]   ram_di_o,
  input  logic [DW-1:0]   ram_do_i
);

  localparam logic [AW:0] MEM_LIM = (AW+1)'(MEM_WORDS);

  state_e        state_q;
  logic          ack_q;
  logic          err_q;
  logic [AW-1:0] cnt_q;

  logic          req;
  logic          in_range;
  logic          burst_go;
  logic [AW-1:0] idx;
  logic [AW:0]   nxt;
  logic          unused_adr;

  assign req        = wbs_cyc_i & wbs_stb_i;
  assign idx        = wbs_adr_i[AW+1:2];
  assign in_range   = {1'b0, idx} < MEM_LIM;
  assign nxt        = {1'b0, cnt_q} + (AW+1)'(1);
  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  // Burst continues only while the master keeps asking for more and the next word exists.
  assign burst_go = (state_q == RD_ACK) && req && !wbs_we_i &&
                    (wbs_cti_i == CTI_INCR) && (nxt < MEM_LIM);

  // RAM strobes are combinational so the macro samples them on the same edge as the request.
  always_comb begin
    ram_en_o = 1'b0;
    ram_we_o = '0;
    ram_a_o  = idx;
    ram_di_o = wbs_dat_i;
    if (RST_N) begin
      case (state_q)
        IDLE: begin
          if (req && in_range) begin
            ram_en_o = 1'b1;
            if (wbs_we_i) ram_we_o = wbs_sel_i;
          end
        end
        RD_ACK: begin
          if (burst_go) begin
            ram_en_o = 1'b1;
            ram_a_o  = nxt[AW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Control FSM; ack/err are registered and never overlap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            if (!in_range) begin
              state_q <= ERR_ACK;
              err_q   <= 1'b1;
            end else begin
              cnt_q   <= idx;
              ack_q   <= 1'b1;
              state_q <= wbs_we_i ? WR_ACK : RD_ACK;
            end
          end
        end
        RD_ACK: begin
          if (burst_go) begin
            cnt_q <= nxt[AW-1:0];
            ack_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = ram_do_i;

endmodule

// File: tb/tb_dffram_wb_bridge.sv
// Bench for dffram_wb_bridge with a behavioural DFFRAM behind it and a word-array reference model.
module tb_dffram_wb_bridge;
  import dffram_pkg::*;

  localparam int MW = 128;

  logic        CLK, RST_N;
  logic        cyc, stb, we;
  logic [9:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_w, dat_r;
  logic [2:0]  cti;
  logic        ack, err, ram_en;
  logic [3:0]  ram_we;
  logic [7:0]  ram_a;
  logic [31:0] ram_di, ram_do;

  logic [31:0] ram_mem   [256];
  logic [31:0] model_mem [256];

  int          n_tests, n_fail;
  logic [31:0] bq[$];
  int          acyc[$];
  int          b_errs;

  dffram_wb_bridge #(.AW(8), .DW(32), .MEM_WORDS(MW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr),
    .wbs_sel_i(sel), .wbs_dat_i(dat_w), .wbs_cti_i(cti),
    .wbs_dat_o(dat_r), .wbs_ack_o(ack), .wbs_err_o(err),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_a_o(ram_a),
    .ram_di_o(ram_di), .ram_do_i(ram_do)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DFFRAM: byte-write, registered read of the pre-write contents.
  always @(posedge CLK) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      ram_do <= ram_mem[ram_a];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_w = '0; cti = CTI_CLASSIC;
  endtask

  task automatic wb_xfer(input logic w, input int idx, input logic [3:0] s, input logic [31:0] d,
                         output logic [31:0] rd, output int lat, output logic got_err);
    cyc = 1'b1; stb = 1'b1; we = w; adr = 10'(idx * 4); sel = s; dat_w = d; cti = CTI_CLASSIC;
    @(negedge CLK);
    check_eq("issue_en", ram_en, idx < MW);
    if (idx < MW) begin
      check_eq("issue_we", ram_we, w ? s : 4'h0);
      check_eq("issue_a", ram_a, idx);
      if (w) check_eq("issue_di", ram_di, d);
    end
    check_eq("issue_ackerr", {ack, err}, 0);
    lat = 0; got_err = 1'b0; rd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (ack || err) begin
        lat = c; got_err = err; rd = dat_r;
        check_eq("ack_err_excl", ack & err, 0);
        check_eq("ackcyc_en", ram_en, 0);
        break;
      end
    end
    @(posedge CLK); #1;
    bus_idle();
  endtask

  task automatic do_single(input logic w, input int idx, input logic [3:0] s,
                           input logic [31:0] d, input string tag);
    logic [31:0] rd;
    int          lat;
    logic        e;
    wb_xfer(w, idx, s, d, rd, lat, e);
    check_eq({tag, "_lat"}, lat, 1);
    if (idx >= MW) check_eq({tag, "_err"}, e, 1);
    else begin
      check_eq({tag, "_err"}, e, 0);
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else check_eq({tag, "_rd"}, rd, model_mem[idx]);
    end
  endtask

  task automatic wb_burst(input int start, input int n, input bit hold);
    int beat = 0;
    bq.delete(); acyc.delete(); b_errs = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 10'(start * 4);
    cti = (hold || n > 1) ? CTI_INCR : CTI_EOB;
    for (int c = 0; c < 40 && beat < n; c++) begin
      @(negedge CLK);
      if (ack) begin bq.push_back(dat_r); acyc.push_back(c); beat++; end
      else if (err) begin b_errs++; beat++; end
      @(posedge CLK); #1;
      if (beat < n) begin
        adr = 10'((start + beat) * 4);
        cti = (hold || beat < n - 1) ? CTI_INCR : CTI_EOB;
      end
    end
    bus_idle();
    check_eq("burst_done", beat, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap200;
    int          seen;
    n_tests = 0; n_fail = 0;
    bus_idle();
    RST_N = 1'b0;
    cyc = 1'b1; stb = 1'b1; adr = 10'h010;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_en", ram_en, 0);
    check_eq("rst_we", ram_we, 0);
    bus_idle();
    RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < MW; i++) do_single(1'b1, i, 4'hF, 32'(i), "preload");

    do_single(1'b1, 4, 4'hF, 32'hDEADBEEF, "t1_wr");
    do_single(1'b0, 4, 4'h0, 32'h0, "t1_rd");
    do_single(1'b1, 4, 4'b0010, 32'h0000AA00, "t2_wr");
    begin
      logic [31:0] rd; int lat; logic e;
      wb_xfer(1'b0, 4, 4'hF, 32'h0, rd, lat, e);
      check_eq("t2_rd", rd, 32'hDEADAAEF);
    end
    do_single(1'b1, 4, 4'h0, 32'h12345678, "sel0_wr");
    do_single(1'b0, 4, 4'h0, 32'h0, "sel0_rd");

    wb_burst(10, 5, 1'b0);
    check_eq("t3_cnt", bq.size(), 5);
    for (int k = 0; k < bq.size(); k++) begin
      check_eq("t3_dat", bq[k], 32'(10 + k));
      check_eq("t3_cyc", acyc[k], k + 1);
    end

    wb_burst(MW - 2, 3, 1'b1);
    check_eq("t4_acks", bq.size(), 2);
    check_eq("t4_errs", b_errs, 1);
    for (int k = 0; k < bq.size(); k++) check_eq("t4_dat", bq[k], 32'(MW - 2 + k));

    snap200 = ram_mem[200];
    do_single(1'b0, 200, 4'hF, 32'h0, "t5_rd");
    do_single(1'b1, 200, 4'hF, 32'hCAFEF00D, "t5_wr");
    check_eq("t5_mem200", ram_mem[200], snap200);
    check_eq("t5_mem72", ram_mem[72], model_mem[72]);

    // Master abandons a speculative burst beat.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 10'(20 * 4); cti = CTI_INCR;
    @(negedge CLK); @(negedge CLK);
    check_eq("cancel_ack1", ack, 1);
    check_eq("cancel_dat1", dat_r, model_mem[20]);
    @(posedge CLK); #1; bus_idle();
    @(negedge CLK);
    check_eq("cancel_ack2", ack, 1);
    @(negedge CLK);
    check_eq("cancel_ack3", ack, 0);
    @(posedge CLK); #1;

    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 10'(10 * 4); cti = CTI_INCR;
    seen = 0;
    for (int c = 0; c < 10 && seen < 2; c++) begin
      @(negedge CLK);
      if (ack) seen++;
      if (seen < 2) begin @(posedge CLK); #1; end
    end
    check_eq("t6_pre_acks", seen, 2);
    #1 RST_N = 1'b0;
    #1;
    check_eq("t6_ack", ack, 0);
    check_eq("t6_err", err, 0);
    check_eq("t6_en", ram_en, 0);
    bus_idle();
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    begin
      logic [31:0] rd; int lat; logic e;
      wb_xfer(1'b0, 10, 4'hF, 32'h0, rd, lat, e);
      check_eq("t6_lat", lat, 1);
      check_eq("t6_rd", rd, 32'd10);
    end

    for (int it = 0; it < 150; it++) begin
      int kind;
      kind = $urandom_range(0, 7);
      if (kind < 6) begin
        int idx;
        idx = ($urandom_range(0, 7) == 0) ? $urandom_range(MW, 255) : $urandom_range(0, MW - 1);
        do_single(kind[0], idx, 4'($urandom), $urandom, "rnd");
      end else begin
        int n, st;
        n  = $urandom_range(1, 6);
        st = $urandom_range(0, MW - n);
        wb_burst(st, n, 1'b0);
        check_eq("rnd_bcnt", bq.size(), n);
        for (int k = 0; k < bq.size(); k++) check_eq("rnd_bdat", bq[k], model_mem[st + k]);
      end
      if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
